// File: rtl/hamming_decode.sv
// Two-stage single-error-correcting Hamming decoder on a valid/ready stream.
// Optional error counters are enabled by defining HAMMING_DEC_ERR_COUNT_EN.
module hamming_decode #(
  parameter int N       = 7,
  parameter int R       = 4,
  parameter int COUNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:N+R]   enStream,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [1:N]     stream,
  output logic           corrected,
  output logic           uncorrectable,
  output logic [R-1:0]   syndrome
`ifdef HAMMING_DEC_ERR_COUNT_EN
  ,
  input  logic               err_clr,
  output logic [COUNT_W-1:0] corr_count,
  output logic [COUNT_W-1:0] uncorr_count
`endif
);

  localparam int L = N + R;

  if ((1 << R) < L + 1 || COUNT_W < 1) begin : g_bad_params
    $error("hamming_decode: parameters do not form a valid code");
  end

  // Codeword position holding data bit i (data fills non-power-of-two slots in order).
  function automatic int data_pos(input int i);
    int k;
    int pos;
    k   = 0;
    pos = 1;
    for (int p = 1; p <= L; p++) begin
      if ((p & (p - 1)) != 0) begin
        k++;
        if (k == i) pos = p;
      end
    end
    return pos;
  endfunction

  logic           s1_valid_q, s1_valid_d;
  logic [1:L]     s1_cw_q, s1_cw_d;
  logic [R-1:0]   s1_syn_q, s1_syn_d;
  logic           out_valid_q, out_valid_d;
  logic [1:N]     stream_q, stream_d;
  logic           corr_q, corr_d;
  logic           unc_q, unc_d;
  logic [R-1:0]   syn_q, syn_d;

  logic           s2_adv, in_rdy, in_fire, fix_hit;
  logic [R-1:0]   syn_in;
  logic [1:L]     cw_fix;
  logic [1:N]     data_x;

  always_comb begin
    syn_in = '0;
    for (int p = 1; p <= L; p++) begin
      if (enStream[p]) syn_in ^= R'(p);
    end
  end

  always_comb begin
    fix_hit = (s1_syn_q != '0) && (int'(s1_syn_q) <= L);
    cw_fix  = s1_cw_q;
    for (int p = 1; p <= L; p++) begin
      if (fix_hit && int'(s1_syn_q) == p) cw_fix[p] = ~s1_cw_q[p];
    end
    data_x = '0;
    for (int i = 1; i <= N; i++) begin
      data_x[i] = cw_fix[data_pos(i)];
    end
  end

  always_comb begin
    s2_adv  = !out_valid_q || out_ready;
    in_rdy  = !s1_valid_q || s2_adv;
    in_fire = in_valid && in_rdy;

    s1_valid_d  = s1_valid_q;
    s1_cw_d     = s1_cw_q;
    s1_syn_d    = s1_syn_q;
    out_valid_d = out_valid_q;
    stream_d    = stream_q;
    corr_d      = corr_q;
    unc_d       = unc_q;
    syn_d       = syn_q;

    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_cw_d    = enStream;
      s1_syn_d   = syn_in;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        stream_d = data_x;
        corr_d   = fix_hit;
        unc_d    = (s1_syn_q != '0) && !fix_hit;
        syn_d    = s1_syn_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      out_valid_q <= 1'b0;
      stream_q    <= '0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
      syn_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      out_valid_q <= out_valid_d;
      stream_q    <= stream_d;
      corr_q      <= corr_d;
      unc_q       <= unc_d;
      syn_q       <= syn_d;
    end
  end

  assign in_ready      = in_rdy;
  assign out_valid     = out_valid_q;
  assign stream        = stream_q;
  assign corrected     = corr_q;
  assign uncorrectable = unc_q;
  assign syndrome      = syn_q;

`ifdef HAMMING_DEC_ERR_COUNT_EN
  logic [COUNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [COUNT_W-1:0] unc_cnt_q, unc_cnt_d;
  logic               out_fire;

  // Counters saturate; a clear overrides any same-cycle increment.
  always_comb begin
    out_fire   = out_valid_q && out_ready;
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (err_clr) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else begin
      if (out_fire && corr_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + COUNT_W'(1);
      if (out_fire && unc_q && unc_cnt_q != '1) unc_cnt_d = unc_cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign corr_count   = corr_cnt_q;
  assign uncorr_count = unc_cnt_q;
`endif

endmodule

// File: tb/tb_hamming_decode.sv
// Randomized scoreboard bench for hamming_decode; counter checks run when
// HAMMING_DEC_ERR_COUNT_EN is defined.
module tb_hamming_decode;
  localparam int N = 7;
  localparam int R = 4;
  localparam int L = N + R;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, corrected, uncorrectable;
  logic [1:L]   enStream;
  logic [1:N]   stream;
  logic [R-1:0] syndrome;

`ifdef HAMMING_DEC_ERR_COUNT_EN
  logic         err_clr;
  logic [15:0]  corr_count, uncorr_count;
  logic         in_ready2, out_valid2, corrected2, uncorrectable2;
  logic [1:N]   stream2;
  logic [R-1:0] syndrome2;
  logic [1:0]   corr_count2, uncorr_count2;
`endif

  hamming_decode #(.N(N), .R(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .enStream(enStream), .out_valid(out_valid), .out_ready(out_ready),
    .stream(stream), .corrected(corrected), .uncorrectable(uncorrectable),
    .syndrome(syndrome)
`ifdef HAMMING_DEC_ERR_COUNT_EN
    , .err_clr(err_clr), .corr_count(corr_count), .uncorr_count(uncorr_count)
`endif
  );

`ifdef HAMMING_DEC_ERR_COUNT_EN
  hamming_decode #(.N(N), .R(R), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .enStream(enStream), .out_valid(out_valid2), .out_ready(out_ready),
    .stream(stream2), .corrected(corrected2), .uncorrectable(uncorrectable2),
    .syndrome(syndrome2), .err_clr(err_clr), .corr_count(corr_count2),
    .uncorr_count(uncorr_count2)
  );
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:N]   data;
    logic [R-1:0] syn;
    logic         corr;
    logic         unc;
  } exp_t;

  exp_t q[$];

  // Reference decode: syndrome is the XOR of the indices of all set positions.
  function automatic exp_t model(input logic [1:L] cw);
    exp_t e;
    logic [1:L] c;
    int syn, k;
    c   = cw;
    syn = 0;
    for (int p = 1; p <= L; p++) if (c[p]) syn = syn ^ p;
    if (syn >= 1 && syn <= L) c[syn] = ~c[syn];
    e.data = '0;
    k = 1;
    for (int p = 1; p <= L; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[k] = c[p];
        k++;
      end
    end
    e.syn  = R'(syn);
    e.corr = (syn >= 1 && syn <= L);
    e.unc  = (syn > L);
    return e;
  endfunction

  // Encode random data with even parity, then inject 0, 1 or 2 bit errors.
  function automatic logic [1:L] gen_word();
    logic [1:L] c;
    logic [1:N] d;
    logic       par;
    int k, ne, a, b;
    c = '0;
    d = N'($urandom);
    k = 1;
    for (int p = 1; p <= L; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int pp = 1; pp <= L; pp = pp * 2) begin
      par = 1'b0;
      for (int p = 1; p <= L; p++) if (p != pp && (p & pp) != 0) par ^= c[p];
      c[pp] = par;
    end
    ne = $urandom_range(0, 2);
    a  = $urandom_range(1, L);
    b  = a + $urandom_range(1, L - 1);
    if (b > L) b = b - L;
    if (ne >= 1) c[a] = ~c[a];
    if (ne == 2) c[b] = ~c[b];
    return c;
  endfunction

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  initial begin : monitor
    logic        stall;
    logic [31:0] prev_out, cur;
    exp_t        e;
    stall    = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      cur = 32'({stream, syndrome, corrected, uncorrectable});
      if (rst) begin
        q.delete();
      end else begin
        if (stall) chk("hold_stable", cur, prev_out);
        if (out_valid) chk("flags_exclusive", 32'(corrected & uncorrectable), 0);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_out", 1, 0);
          end else begin
            e = q.pop_front();
            chk("sb_data", 32'(stream), 32'(e.data));
            chk("sb_syndrome", 32'(syndrome), 32'(e.syn));
            chk("sb_flags", 32'({corrected, uncorrectable}), 32'({e.corr, e.unc}));
          end
        end
        if (in_valid && in_ready) q.push_back(model(enStream));
      end
      stall    = !rst && out_valid && !out_ready;
      prev_out = cur;
    end
  end

  task automatic send(input logic [1:L] w);
    in_valid = 1'b1;
    enStream = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    chk("send_timeout", 1, 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    i = 0;
    while ((q.size() != 0 || out_valid) && i < 100) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [1:L] w, input int e_data,
                          input int e_syn, input int e_corr, input int e_unc);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    enStream  = w;
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, "_early"}, 32'(out_valid), 0);
    @(posedge clk);
    #1;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_stream"}, 32'(stream), 32'(e_data));
    chk({tag, "_syndrome"}, 32'(syndrome), 32'(e_syn));
    chk({tag, "_corr"}, 32'(corrected), 32'(e_corr));
    chk({tag, "_unc"}, 32'(uncorrectable), 32'(e_unc));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    int n_sent, cyc;
    logic took;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    enStream  = '0;
`ifdef HAMMING_DEC_ERR_COUNT_EN
    err_clr   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_outputs", 32'({stream, syndrome, corrected, uncorrectable}), 0);

    directed("clean", 11'd668, 12, 0, 0, 0);
    directed("data_err", 11'd732, 12, 5, 1, 0);
    directed("parity_err", 11'd156, 12, 2, 1, 0);
    directed("double_err", 11'd532, 12, 12, 0, 1);

`ifdef HAMMING_DEC_ERR_COUNT_EN
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("cnt_clr_corr", 32'(corr_count), 0);
    directed("cnt_a", 11'd732, 12, 5, 1, 0);
    directed("cnt_b", 11'd156, 12, 2, 1, 0);
    directed("cnt_c", 11'd732, 12, 5, 1, 0);
    directed("cnt_d", 11'd532, 12, 12, 0, 1);
    chk("corr_count", 32'(corr_count), 3);
    chk("uncorr_count", 32'(uncorr_count), 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("clr_corr_count", 32'(corr_count), 0);
    chk("clr_uncorr_count", 32'(uncorr_count), 0);
    for (int i = 0; i < 5; i++) directed("sat", 11'd732, 12, 5, 1, 0);
    chk("corr_count_5", 32'(corr_count), 5);
    chk("corr_count_sat", 32'(corr_count2), 3);
`endif

    // Backpressure: two accepts fill the pipe, then in_ready drops.
    out_ready = 1'b0;
    send(gen_word());
    send(gen_word());
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    in_valid = 1'b1;
    enStream = gen_word();
    repeat (5) @(posedge clk);
    #1;
    chk("bp_still_full", 32'(in_ready), 0);
    out_ready = 1'b1;
    send(enStream);
    send(gen_word());
    drain();

    // Reset mid-stream discards in-flight words.
    out_ready = 1'b0;
    send(gen_word());
    send(gen_word());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", 32'(out_valid), 0);
    end

    // Randomized traffic with random gaps and backpressure.
    n_sent   = 0;
    cyc      = 0;
    in_valid = 1'b0;
    while (n_sent < 300 && cyc < 20000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        enStream = gen_word();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (took) begin
        in_valid = 1'b0;
        n_sent++;
      end
      cyc++;
    end
    chk("rand_sent", 32'(n_sent), 300);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
